ssram_port_arbiter: RTL and testbench

- Shares one synchronous port of the JTAG interface's 512x32 dual-port SSRAM between two requesters: requester 0 is the JTAG shift engine and requester 1 is the bus-side DMA.
- Issues at most one access per clock and grants round-robin.
- Supports locked bursts so a requester can own the port for consecutive words.
- Returns read data with the SSRAM's one-cycle registered latency, and guards against starvation with a lock timeout.

---
 rtl/ssram_arb_pkg.sv | 22 ++
 rtl/ssram_port_arbiter_if.sv | 42 ++++
 rtl/ssram_port_arbiter.sv | 117 +++++++++++
 tb/tb_ssram_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ssram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arb_pkg
// Brief    : Shared types and constants for the SSRAM port arbiter.
// Revision : 1.0
// ============================================================================
package ssram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic JTAG_REQ = 1'b0;
    localparam logic DMA_REQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ssram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ssram_port_arbiter_if
// Brief    : Requester handshake and SSRAM port signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface ssram_port_arbiter_if
    import ssram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req0, req1;
    logic                  lock0, lock1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  lockTimeout;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memWriteEnable;
    logic [DATA_WIDTH-1:0] memDataIn;
    logic [DATA_WIDTH-1:0] memDataOut;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, memDataOut,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lockTimeout,
               memAddress, memWriteEnable, memDataIn
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, memDataOut,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lockTimeout,
               memAddress, memWriteEnable, memDataIn
    );

endinterface
`default_nettype wire

// File: rtl/ssram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssram_port_arbiter
// Brief    : Round-robin, lock-capable arbiter sharing one SSRAM port between
//            the JTAG shift engine (0) and the bus-side DMA (1).
// Revision : 1.0
// ============================================================================
module ssram_port_arbiter
    import ssram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  wire logic            clock,
    input  wire logic            reset,
    ssram_port_arbiter_if.slave  bus
);

    localparam logic [7:0] c_LOCK_LIMIT = 8'(MAX_LOCK_CYCLES - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last_grant;
    logic [7:0] r_lock_count;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic       r_lock_timeout;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_at_limit;
    logic       w_forced;

    // The count includes the cycle whose grant took the lock, so a burst
    // owns the port for at most MAX_LOCK_CYCLES consecutive grants.
    assign w_at_limit = (r_lock_count >= c_LOCK_LIMIT);

    always_comb begin
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_next   = r_state;
        w_forced = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt0 = bus.req0 && (!bus.req1 || (r_last_grant == DMA_REQ));
                w_gnt1 = bus.req1 && !w_gnt0;
                if (w_gnt0 && bus.lock0) begin
                    w_next = OWN0;
                end else if (w_gnt1 && bus.lock1) begin
                    w_next = OWN1;
                end
            end
            OWN0: begin
                w_gnt0 = bus.req0;
                if (w_at_limit) begin
                    w_next   = IDLE;
                    w_forced = bus.lock0;
                end else if (!bus.lock0) begin
                    w_next = IDLE;
                end
            end
            OWN1: begin
                w_gnt1 = bus.req1;
                if (w_at_limit) begin
                    w_next   = IDLE;
                    w_forced = bus.lock1;
                end else if (!bus.lock1) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_grant   <= DMA_REQ;
            r_lock_count   <= 8'd0;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt0) begin
                r_last_grant <= JTAG_REQ;
            end else if (w_gnt1) begin
                r_last_grant <= DMA_REQ;
            end
            if (r_state == IDLE) begin
                r_lock_count <= 8'd1;
            end else begin
                r_lock_count <= r_lock_count + 8'd1;
            end
            r_rvalid0      <= w_gnt0 & ~bus.we0;
            r_rvalid1      <= w_gnt1 & ~bus.we1;
            r_lock_timeout <= w_forced;
        end
    end

    assign bus.gnt0           = w_gnt0;
    assign bus.gnt1           = w_gnt1;
    assign bus.rvalid0        = r_rvalid0;
    assign bus.rvalid1        = r_rvalid1;
    assign bus.rdata0         = bus.memDataOut;
    assign bus.rdata1         = bus.memDataOut;
    assign bus.lockTimeout    = r_lock_timeout;
    assign bus.memAddress     = w_gnt0 ? bus.addr0  : (w_gnt1 ? bus.addr1  : {ADDR_WIDTH{1'b0}});
    assign bus.memDataIn      = w_gnt0 ? bus.wdata0 : (w_gnt1 ? bus.wdata1 : {DATA_WIDTH{1'b0}});
    assign bus.memWriteEnable = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);

endmodule
`default_nettype wire

// File: tb/tb_ssram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssram_port_arbiter
// Brief    : Scoreboard bench for ssram_port_arbiter with a behavioural SSRAM.
// Revision : 1.0
// ============================================================================
module tb_ssram_port_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int MAXL = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ssram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ssram_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_LOCK_CYCLES (MAXL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ssram   [0:511];
    logic [DW-1:0] ref_mem [0:511];

    always @(posedge clock) begin
        if (bus.memWriteEnable) ssram[bus.memAddress] <= bus.memDataIn;
        bus.memDataOut <= ssram[bus.memAddress];
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic r, input logic l, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0 = r; bus.lock0 = l; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic l, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1 = r; bus.lock1 = l; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic drop();
        set0(1'b0, 1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: check returns due now, check the grant decision, record
    // the expected effect of any granted access, then advance.
    task automatic step(input string tag, input logic e_g0, input logic e_g1, input logic e_to);
        rd_t  r;
        logic ev0;
        logic ev1;
        @(negedge clock);
        ev0    = 1'b0;
        ev1    = 1'b0;
        r.port = 1'b0;
        r.data = '0;
        if (sb.size() != 0) begin
            r   = sb.pop_front();
            ev0 = (r.port == 1'b0);
            ev1 = (r.port == 1'b1);
        end
        check({tag, ".rvalid0"}, 32'(bus.rvalid0), 32'(ev0));
        check({tag, ".rvalid1"}, 32'(bus.rvalid1), 32'(ev1));
        if (ev0) check({tag, ".rdata0"}, bus.rdata0, r.data);
        if (ev1) check({tag, ".rdata1"}, bus.rdata1, r.data);
        check({tag, ".gnt0"}, 32'(bus.gnt0), 32'(e_g0));
        check({tag, ".gnt1"}, 32'(bus.gnt1), 32'(e_g1));
        check({tag, ".lockTimeout"}, 32'(bus.lockTimeout), 32'(e_to));
        check({tag, ".memWE"}, 32'(bus.memWriteEnable), 32'((e_g0 & bus.we0) | (e_g1 & bus.we1)));
        if (e_g0) begin
            check({tag, ".addr"}, 32'(bus.memAddress), 32'(bus.addr0));
            if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
            else         sb.push_back('{1'b0, ref_mem[bus.addr0]});
        end else if (e_g1) begin
            check({tag, ".addr"}, 32'(bus.memAddress), 32'(bus.addr1));
            if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
            else         sb.push_back('{1'b1, ref_mem[bus.addr1]});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            ssram[i]   = 32'hA5000000 + (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 + (i * 32'h00010203);
        end
        ssram[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        reset = 1'b1;
        drop();
        repeat (2) @(posedge clock);
        #1;

        // Requests and a write are presented while reset is held.
        set0(1'b1, 1'b1, 1'b1, 9'd3, 32'h0BAD0BAD);
        set1(1'b1, 1'b0, 1'b1, 9'd4, 32'h0BAD0BAD);
        step("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drop();
        step("idle", 1'b0, 1'b0, 1'b0);

        // Single read of address 5.
        set0(1'b1, 1'b0, 1'b0, 9'd5, '0);
        step("t1c0", 1'b1, 1'b0, 1'b0);
        drop();
        step("t1c1", 1'b0, 1'b0, 1'b0);

        // Requester 1 alone, then both contend without lock.
        set1(1'b1, 1'b0, 1'b0, 9'd6, '0);
        step("t2w", 1'b0, 1'b1, 1'b0);
        set0(1'b1, 1'b0, 1'b0, 9'd20, '0);
        set1(1'b1, 1'b0, 1'b0, 9'd21, '0);
        step("t2c0", 1'b1, 1'b0, 1'b0);
        step("t2c1", 1'b0, 1'b1, 1'b0);
        step("t2c2", 1'b1, 1'b0, 1'b0);
        step("t2c3", 1'b0, 1'b1, 1'b0);
        drop();
        step("t2d", 1'b0, 1'b0, 1'b0);

        // Write then read back the same address.
        set0(1'b1, 1'b0, 1'b1, 9'd7, 32'h12345678);
        step("t3w", 1'b1, 1'b0, 1'b0);
        set0(1'b1, 1'b0, 1'b0, 9'd7, '0);
        step("t3r", 1'b1, 1'b0, 1'b0);
        drop();
        step("t3d", 1'b0, 1'b0, 1'b0);
        check("t3.newdata", ref_mem[7], 32'h12345678);

        // Locked 4-word burst from requester 0 against a busy requester 1.
        set1(1'b1, 1'b0, 1'b0, 9'd8, '0);
        step("t4w", 1'b0, 1'b1, 1'b0);
        set1(1'b1, 1'b0, 1'b0, 9'd30, '0);
        for (int k = 0; k < 4; k++) begin
            set0(1'b1, (k < 3), 1'b0, 9'(10 + k), '0);
            step($sformatf("t4b%0d", k), 1'b1, 1'b0, 1'b0);
        end
        set0(1'b0, 1'b0, 1'b0, '0, '0);
        step("t4c4", 1'b0, 1'b1, 1'b0);
        drop();
        step("t4d", 1'b0, 1'b0, 1'b0);

        // Requester 1 holds its lock past the limit.
        set0(1'b1, 1'b0, 1'b0, 9'd9, '0);
        step("t5w", 1'b1, 1'b0, 1'b0);
        set0(1'b1, 1'b0, 1'b0, 9'd40, '0);
        set1(1'b1, 1'b1, 1'b0, 9'd41, '0);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("t5c%0d", k), 1'b0, 1'b1, 1'b0);
        end
        step("t5c4", 1'b1, 1'b0, 1'b1);
        drop();
        step("t5d", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a locked burst.
        set0(1'b1, 1'b1, 1'b0, 9'd60, '0);
        step("t6c0", 1'b1, 1'b0, 1'b0);
        set0(1'b1, 1'b1, 1'b0, 9'd61, '0);
        step("t6c1", 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        set0(1'b1, 1'b1, 1'b1, 9'd62, 32'hCAFE0000);
        set1(1'b1, 1'b1, 1'b1, 9'd63, 32'hCAFE0001);
        step("t6rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 9'd50, '0);
        set1(1'b1, 1'b0, 1'b0, 9'd51, '0);
        step("t6c3", 1'b1, 1'b0, 1'b0);
        step("t6c4", 1'b0, 1'b1, 1'b0);
        drop();
        step("t6d", 1'b0, 1'b0, 1'b0);
        step("end", 1'b0, 1'b0, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
